adc_avg_fifo: RTL and testbench

ADC_AVG_FIFO -- requirements
Module: adc_avg_fifo

---
 rtl/adc_avg_fifo_pkg.sv | 27 ++
 rtl/adc_avg_fifo_sync.sv | 55 +++++
 rtl/adc_avg_fifo.sv | 164 ++++++++++++++++
 tb/tb_adc_avg_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/adc_avg_fifo_pkg.sv
// Shared types and width helpers for the ADC block-averaging front end.
package adc_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  function automatic int acc_w(input int adc_w, input int avg_log2);
    return adc_w + avg_log2;
  endfunction

  function automatic int cnt_w(input int avg_log2);
    return (avg_log2 < 1) ? 1 : avg_log2;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Widths for the default configuration (8-bit samples, 4-sample blocks, 4 entries).
  localparam int ACC_W = acc_w(8, 2);
  localparam int CNT_W = cnt_w(2);
  localparam int LVL_W = lvl_w(4);

endpackage

// File: rtl/adc_avg_fifo_sync.sv
// Synchronous first-word-fall-through FIFO; m_data reads as zero while empty.
module adc_sync_fifo
  import adc_avg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [lvl_w(DEPTH)-1:0]   o_level
);

  localparam int LvlW = lvl_w(DEPTH);
  localparam int AddrW = LvlW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LvlW-1:0]  r_wr;
  logic [LvlW-1:0]  r_rd;
  logic [LvlW-1:0]  w_level;
  logic             w_re;
  logic             w_we;

  always_comb begin
    w_level = r_wr - r_rd;
    o_empty = (w_level == '0);
    o_full  = (w_level == LvlW'(DEPTH));
    w_re    = i_pop && !o_empty;
    // A pop frees the slot being written, so a full FIFO still accepts a coincident push.
    w_we    = i_push && (!o_full || w_re);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_we) r_wr <= r_wr + LvlW'(1);
      if (w_re) r_rd <= r_rd + LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr[AddrW-1:0]] <= i_data;
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd[AddrW-1:0]];
  assign o_level = w_level;

endmodule

// File: rtl/adc_avg_fifo.sv
// Averages blocks of 2^AVG_LOG2 ADC samples and queues results in a FWFT FIFO.
// Define ADC_AVG_MINMAX_EN to report per-block min/max on blk_min/blk_max.
module adc_avg_fifo
  import adc_avg_pkg::*;
#(
  parameter int ADC_WIDTH  = 8,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_eoc,
  input  logic [ADC_WIDTH-1:0]          s_data,
  input  logic                          clr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ADC_WIDTH-1:0]          m_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic [ADC_WIDTH-1:0]          blk_min,
  output logic [ADC_WIDTH-1:0]          blk_max
);

  localparam int AccW = acc_w(ADC_WIDTH, AVG_LOG2);
  localparam int CntW = cnt_w(AVG_LOG2);
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AccW-1:0]      r_acc;
  logic [CntW-1:0]      r_cnt;
  logic [ADC_WIDTH-1:0] r_res;
  logic                 r_ovf;
  logic [AccW-1:0]      w_sum;
  logic [CntW-1:0]      w_cnt_cur;
  logic                 w_first;
  logic                 w_last;
  logic                 w_take;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;

  // Any sample outside ACC opens a new block, so IDLE and EMIT share one path.
  always_comb begin
    w_first   = (r_state != ST_ACC);
    w_cnt_cur = w_first ? '0 : r_cnt;
    w_sum     = (w_first ? '0 : r_acc) + AccW'(s_data);
    w_last    = (w_cnt_cur == CntLast);
    w_take    = s_eoc && !clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr)                     w_state_nxt = ST_IDLE;
    else if (s_eoc)              w_state_nxt = w_last ? ST_EMIT : ST_ACC;
    else if (r_state == ST_EMIT) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    w_push = (r_state == ST_EMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (s_eoc) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_res <= ADC_WIDTH'(w_sum >> AVG_LOG2);
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_cur + CntW'(1);
      end
    end
  end

  assign w_pop = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf <= 1'b0;
    else        r_ovf <= (r_ovf && !clr) || (w_push && w_full && !w_pop);
  end

  assign ovf     = r_ovf;
  assign m_valid = !w_empty;

  adc_sync_fifo #(
    .WIDTH (ADC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_res),
    .i_pop   (m_ready),
    .o_data  (m_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

`ifdef ADC_AVG_MINMAX_EN
  logic [ADC_WIDTH-1:0] r_run_min;
  logic [ADC_WIDTH-1:0] r_run_max;
  logic [ADC_WIDTH-1:0] r_res_min;
  logic [ADC_WIDTH-1:0] r_res_max;
  logic [ADC_WIDTH-1:0] r_blk_min;
  logic [ADC_WIDTH-1:0] r_blk_max;
  logic [ADC_WIDTH-1:0] w_min_nxt;
  logic [ADC_WIDTH-1:0] w_max_nxt;

  always_comb begin
    w_min_nxt = (w_first || (s_data < r_run_min)) ? s_data : r_run_min;
    w_max_nxt = (w_first || (s_data > r_run_max)) ? s_data : r_run_max;
  end

  // Final extremes are parked with the result so a back-to-back block cannot disturb them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run_min <= '0;
      r_run_max <= '0;
      r_res_min <= '0;
      r_res_max <= '0;
      r_blk_min <= '0;
      r_blk_max <= '0;
    end else begin
      if (w_take) begin
        if (w_last) begin
          r_res_min <= w_min_nxt;
          r_res_max <= w_max_nxt;
        end else begin
          r_run_min <= w_min_nxt;
          r_run_max <= w_max_nxt;
        end
      end
      if (w_push) begin
        r_blk_min <= r_res_min;
        r_blk_max <= r_res_max;
      end
    end
  end

  assign blk_min = r_blk_min;
  assign blk_max = r_blk_max;
`else
  logic w_take_unused;
  assign w_take_unused = w_take;
  assign blk_min = '0;
  assign blk_max = '0;
`endif

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Directed bench for adc_avg_fifo at ADC_WIDTH=8, AVG_LOG2=2, FIFO_DEPTH=4.
module tb_adc_avg_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_eoc = 1'b0;
  logic [7:0] s_data = '0;
  logic       clr = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [2:0] level;
  logic       ovf;
  logic [7:0] blk_min;
  logic [7:0] blk_max;

  int total = 0;
  int bad = 0;

`ifdef ADC_AVG_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  adc_avg_fifo #(
    .ADC_WIDTH  (8),
    .AVG_LOG2   (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_eoc   (s_eoc),
    .s_data  (s_data),
    .clr     (clr),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level),
    .ovf     (ovf),
    .blk_min (blk_min),
    .blk_max (blk_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    s_eoc  = 1'b1;
    s_data = v;
    tick();
    s_eoc  = 1'b0;
  endtask

  task automatic block(input logic [7:0] v);
    for (int i = 0; i < 4; i++) sample(v);
  endtask

  initial begin
    tick();
    tick();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_min", 32'(blk_min), 0);
    check("rst_max", 32'(blk_max), 0);
    rst_n = 1'b1;

    // Basic average and one-cycle latency
    sample(8'd10); sample(8'd20); sample(8'd30); sample(8'd40);
    check("lat_not_yet", 32'(m_valid), 0);
    tick();
    check("avg_valid", 32'(m_valid), 1);
    check("avg_data", 32'(m_data), 25);
    check("avg_level", 32'(level), 1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    check("pop_empty", 32'(m_valid), 0);

    // Full-scale and truncation, back-to-back blocks
    block(8'd255);
    sample(8'd3); sample(8'd3); sample(8'd3); sample(8'd4);
    tick();
    check("fs_level", 32'(level), 2);
    check("fs_data", 32'(m_data), 255);
    m_ready = 1'b1;
    tick();
    check("trunc_data", 32'(m_data), 3);
    check("trunc_level", 32'(level), 1);
    tick();
    check("drain_level", 32'(level), 0);
    m_ready = 1'b0;

    // Overflow drop with m_ready low
    for (int b = 1; b <= 5; b++) block(8'(b));
    tick();
    check("ovf_level", 32'(level), 4);
    check("ovf_flag", 32'(ovf), 1);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain", 32'(m_data), 32'(i));
      tick();
    end
    m_ready = 1'b0;
    check("ovf_empty", 32'(level), 0);
    check("ovf_sticky", 32'(ovf), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);

    // Push and pop together while full
    for (int b = 6; b <= 10; b++) block(8'(b));
    check("full_pre", 32'(level), 4);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    check("pp_level", 32'(level), 4);
    check("pp_ovf", 32'(ovf), 0);
    check("pp_head", 32'(m_data), 7);
    m_ready = 1'b1;
    for (int i = 7; i <= 10; i++) begin
      check("pp_drain", 32'(m_data), 32'(i));
      tick();
    end
    m_ready = 1'b0;

    // clr discards partial block and a coincident sample
    sample(8'd100); sample(8'd100);
    clr = 1'b1; sample(8'd200); clr = 1'b0;
    sample(8'd8); sample(8'd8); sample(8'd8);
    tick();
    check("clr_none", 32'(level), 0);
    sample(8'd8);
    tick();
    check("clr_level", 32'(level), 1);
    check("clr_data", 32'(m_data), 8);

    // Mid-block reset with a non-empty FIFO
    sample(8'd7); sample(8'd7); sample(8'd7);
    rst_n = 1'b0; tick();
    check("mrst_valid", 32'(m_valid), 0);
    check("mrst_level", 32'(level), 0);
    check("mrst_data", 32'(m_data), 0);
    check("mrst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    block(8'd50);
    tick();
    check("post_rst_data", 32'(m_data), 50);
    check("post_rst_level", 32'(level), 1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;

    // Min/max tracking
    sample(8'd5); sample(8'd200); sample(8'd7); sample(8'd100);
    tick();
    check("mm_data", 32'(m_data), 78);
    check("mm_min", 32'(blk_min), MM ? 32'd5 : 32'd0);
    check("mm_max", 32'(blk_max), MM ? 32'd200 : 32'd0);
    m_ready = 1'b1; tick(); m_ready = 1'b0;

    // clr during EMIT still pushes
    block(8'd9);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_emit_level", 32'(level), 1);
    check("clr_emit_data", 32'(m_data), 9);
    check("clr_emit_min", 32'(blk_min), MM ? 32'd9 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
